aes_dec_key_sched: RTL and testbench
====================================

# aes_dec_key_sched

Iterative AES-128 decryption key scheduler. It accepts a cipher key and expands forward, one round per cycle, to the round-10 key. It then serves round keys in reverse order (10 down to 0), one step per `i_next` request, using the inverse key-expansion recurrence. It sits in front of the AESTOP datapath so that decrypt mode can consume round keys last-first without storing all 11 keys.

## Interface
- `NR`, default 10: number of rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: loads `i_key` and starts forward expansion. Honoured in IDLE and SERVE only.
- `i_key`, in, 128: cipher key. Byte 0 is `[127:120]`; word w0 is `[127:96]`.
- `i_next`, in, 1: consumes the presented round key and requests the previous one. Honoured in SERVE only.
- `o_busy`, out, 1: high while in EXPAND.
- `o_key_valid`, out, 1: high in SERVE; `o_round_key` is meaningful.
- `o_round_key`, out, 128: current key register.
- `o_round`, out, 4: round index of `o_round_key` (0..10).
- `o_done`, out, 1: one-cycle pulse after round key 0 is consumed.

## Operation
- States: IDLE, EXPAND, SERVE. One key register `kr` (128 b) and one round counter `rc` (4 b).
- **IDLE**
  - `i_start`: `kr <= i_key`, `rc <= 0`, go to EXPAND.
  - `i_next`: ignored.
- **EXPAND** (forward step, using rcon[`rc`+1])
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - `rc <= rc + 1`. When `rc` becomes 10, go to SERVE.
  - `i_start` and `i_next` are ignored.
- **SERVE**
  - `i_next` with `rc > 0` (inverse step, using rcon[`rc`]):
    - w3 = w3' ^ w2'; w2 = w2' ^ w1'; w1 = w1' ^ w0'
    - w0 = w0' ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    - `rc <= rc - 1`
  - `i_next` with `rc == 0`: go to IDLE, pulse `o_done`. `kr` keeps round key 0.
  - `i_start`: aborts and restarts exactly as from IDLE. It takes priority over a simultaneous `i_next`.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous, `rst` high): state = IDLE, `kr` = 0, `rc` = 0. All outputs are 0 (`o_busy`, `o_key_valid`, `o_done`, `o_round_key`, `o_round`).
- `i_start` sampled at edge E0: `o_busy` is high from E0 to E10. At E10, `o_busy` falls and `o_key_valid` rises with `o_round` = 10. The round-10 key is available 10 cycles after start.
- Each `i_next` sampled in SERVE updates `o_round_key` and `o_round` at that same edge. The throughput is one key per cycle when `i_next` is held high.
- Full reverse sequence: 10 cycles of expansion, then 11 presentations. Holding `i_next` high gives `o_done` at edge E21, with `o_key_valid` low from E21.
- If `i_next` is low, the current key is held indefinitely.
- `rst` asserted mid-EXPAND or mid-SERVE: immediate return to the reset values. No `o_done` is produced.
- `i_start` and `i_next` high together in IDLE: start only.

## Structure
- Shared package `aes_pkg`:
  - `NR` and the `RCON[1:10]` constant array
  - state enum `dks_state_t` {IDLE, EXPAND, SERVE}
  - function `rot_word`
- Sub-module `aes_sub_word`: 32-bit input to 32-bit output, four forward S-box lookups.
  - One instance only. Its input is muxed between w3 (EXPAND) and the recovered w3 = w3' ^ w2' (SERVE).
  - The S-box table is reused from the existing forward SubByte logic.

## Test plan
- **Reset values.** Pulse `rst` mid-EXPAND (at E5) → all outputs 0 asynchronously, and the state is IDLE on the next edge.
- **FIPS-197 A.1 forward expansion.** `i_key` = 2b7e151628aed2a6abf7158809cf4f3c, `i_start` for 1 cycle → at E10, `o_key_valid` = 1, `o_round` = 10, `o_round_key` = d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Reverse sequence, same key.**
  - First `i_next` → `o_round` = 9, key ac7766f319fadc2128d12941575c006e.
  - At `o_round` = 1 → a0fafe1788542cb123a339392a6c7605.
  - At `o_round` = 0 → 2b7e151628aed2a6abf7158809cf4f3c.
  - One further `i_next` → `o_done` for 1 cycle, `o_key_valid` = 0.
- **Stall.** Drop `i_next` for 7 cycles at `o_round` = 5 → key and round stable. Resume → the sequence continues unchanged.
- **Ignored and abort inputs.**
  - `i_start` with a different key at E4 of EXPAND → ignored; round 10 still matches the first key.
  - `i_start` at `o_round` = 6 → restarts: `o_key_valid` drops, and round 10 of the new key appears 10 cycles later.
- **Random checks.** 10 random keys with the full reverse walk, checked against a reference model. Round 0 must equal `i_key` for every key.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption key scheduler: round count,
// round constants, scheduler state encoding and the RotWord helper.
package aes_pkg;

    localparam int NR = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        SERVE  = 2'd2
    } dks_state_t;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Round 0 has no constant; out-of-range indices yield zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        if ((r >= 4'd1) && (r <= 4'd10)) begin
            v = RCON[r];
        end else begin
            v = 8'h00;
        end
        return v;
    endfunction

endpackage

// File: rtl/aes_dec_key_sched_if.sv
// Request/response bundle between a decrypt datapath and the key scheduler.
interface aes_dec_key_sched_if;

    logic         i_start;
    logic [127:0] i_key;
    logic         i_next;
    logic         o_busy;
    logic         o_key_valid;
    logic [127:0] o_round_key;
    logic [3:0]   o_round;
    logic         o_done;

    modport master (
        output i_start, i_key, i_next,
        input  o_busy, o_key_valid, o_round_key, o_round, o_done
    );

    modport slave (
        input  i_start, i_key, i_next,
        output o_busy, o_key_valid, o_round_key, o_round, o_done
    );

endinterface

// File: rtl/aes_sub_word.sv
// Four parallel forward AES S-box lookups on a 32-bit word.
module aes_sub_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    localparam logic [2047:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

    // Entry 0 sits in the most significant byte of the table.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    // Byte-wise substitution of the whole word.
    always_comb begin
        o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                  sbox(i_word[15:8]),  sbox(i_word[7:0])};
    end

endmodule

// File: rtl/aes_dec_key_sched.sv
// Iterative AES-128 key scheduler: expands forward to round 10, then walks
// back to round 0 with the inverse recurrence, one key per i_next.
module aes_dec_key_sched #(
    parameter int NR = aes_pkg::NR
) (
    input  logic               clk,
    input  logic               rst,
    aes_dec_key_sched_if.slave bus
);
    import aes_pkg::*;

    if (NR != 10) begin : g_nr_check
        $error("aes_dec_key_sched: only NR=10 (AES-128) is supported");
    end

    dks_state_t   r_state;
    logic [127:0] r_kr;
    logic [3:0]   r_rc;
    logic         r_busy;
    logic         r_key_valid;
    logic         r_done;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_w3_prev;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub_out;
    logic [7:0]   w_rcon;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [127:0] w_fwd;
    logic [127:0] w_inv;

    // Word split and S-box input select; in SERVE the previous w3 is
    // recovered first, since the inverse step needs SubWord of that word.
    always_comb begin
        w_w0      = r_kr[127:96];
        w_w1      = r_kr[95:64];
        w_w2      = r_kr[63:32];
        w_w3      = r_kr[31:0];
        w_w3_prev = w_w3 ^ w_w2;
        w_sub_in  = 32'h0000_0000;
        w_rcon    = 8'h00;
        if (r_state == SERVE) begin
            w_sub_in = rot_word(w_w3_prev);
            w_rcon   = rcon_of(r_rc);
        end else begin
            w_sub_in = rot_word(w_w3);
            w_rcon   = rcon_of(r_rc + 4'd1);
        end
    end

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // Next key in either direction; the new w0 is w0 ^ t both ways.
    always_comb begin
        w_t   = w_sub_out ^ {w_rcon, 24'h00_0000};
        w_n0  = w_w0 ^ w_t;
        w_fwd = {w_n0, w_w1 ^ w_n0, w_w2 ^ w_w1 ^ w_n0, w_w3 ^ w_w2 ^ w_w1 ^ w_n0};
        w_inv = {w_n0, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3_prev};
    end

    // Scheduler FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_kr        <= 128'h0;
            r_rc        <= 4'd0;
            r_busy      <= 1'b0;
            r_key_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_kr        <= bus.i_key;
                        r_rc        <= 4'd0;
                        r_state     <= EXPAND;
                        r_busy      <= 1'b1;
                        r_key_valid <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                EXPAND: begin
                    r_kr <= w_fwd;
                    r_rc <= r_rc + 4'd1;
                    if (r_rc == 4'd9) begin
                        r_state     <= SERVE;
                        r_busy      <= 1'b0;
                        r_key_valid <= 1'b1;
                    end else begin
                        r_state <= EXPAND;
                    end
                end
                SERVE: begin
                    if (bus.i_start) begin
                        r_kr        <= bus.i_key;
                        r_rc        <= 4'd0;
                        r_state     <= EXPAND;
                        r_busy      <= 1'b1;
                        r_key_valid <= 1'b0;
                    end else if (bus.i_next) begin
                        if (r_rc != 4'd0) begin
                            r_kr <= w_inv;
                            r_rc <= r_rc - 4'd1;
                        end else begin
                            r_state     <= IDLE;
                            r_key_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end else begin
                        r_state <= SERVE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_key_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_key_valid = r_key_valid;
    assign bus.o_round_key = r_kr;
    assign bus.o_round     = r_rc;
    assign bus.o_done      = r_done;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Randomised bench for aes_dec_key_sched against a table-driven AES-128 key
// expansion model with an S-box derived from GF(2^8) inversion.
module tb_aes_dec_key_sched;

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam int P_IDLE  = 0;
    localparam int P_EXP   = 1;
    localparam int P_SERVE = 2;

    logic clk;
    logic rst;
    aes_dec_key_sched_if bus ();

    aes_dec_key_sched dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic pinned = 1'b0;

    logic [7:0]   sbox_t [0:255];
    int           m_phase = P_IDLE;
    int           m_cnt = 0;
    int           m_round = 0;
    logic [127:0] m_key = 128'h0;
    logic [127:0] m_start_key = 128'h0;
    logic [127:0] m_keys [0:10];
    logic         m_done = 1'b0;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r = {w[23:0], w[31:24]};
        return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
    endfunction

    // Textbook forward expansion to 44 words; returns round key r.
    function automatic logic [127:0] rk_of(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_rot(temp) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ temp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic [127:0] k, input logic n);
        @(negedge clk);
        bus.i_start = s;
        bus.i_key   = k;
        bus.i_next  = n;
    endtask

    // Behavioural model: which round key must be presented after each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_IDLE; m_cnt = 0; m_round = 0; m_key = 128'h0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if ((m_phase != P_EXP) && bus.i_start) begin
                for (int r = 0; r <= 10; r++) m_keys[r] = rk_of(bus.i_key, r);
                m_phase = P_EXP; m_cnt = 0; m_round = 0;
                m_key = bus.i_key; m_start_key = bus.i_key;
            end else if (m_phase == P_EXP) begin
                m_cnt++;
                m_round = m_cnt;
                m_key = m_keys[m_cnt];
                if (m_cnt == 10) m_phase = P_SERVE;
            end else if ((m_phase == P_SERVE) && bus.i_next) begin
                if (m_round > 0) begin
                    m_round--;
                    m_key = m_keys[m_round];
                end else begin
                    m_phase = P_IDLE;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Single compare process: model pins once, then DUT vs model each cycle.
    always @(negedge clk) begin
        if (!pinned) begin
            pinned = 1'b1;
            chk("model_sbox", {104'd0, sbox_t[0], sbox_t[83], sbox_t[255]}, {104'd0, 24'h63ed16});
            chk("model_rk10", rk_of(K_FIPS, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            chk("model_rk9",  rk_of(K_FIPS, 9),  128'hac7766f319fadc2128d12941575c006e);
            chk("model_rk1",  rk_of(K_FIPS, 1),  128'ha0fafe1788542cb123a339392a6c7605);
            chk("model_rk0",  rk_of(K_FIPS, 0),  K_FIPS);
        end
        chk("round_key", bus.o_round_key, m_key);
        chk("busy_valid_done_round",
            {120'd0, bus.o_busy, bus.o_key_valid, bus.o_done, 1'b0, bus.o_round},
            {120'd0, (m_phase == P_EXP), (m_phase == P_SERVE), m_done, 1'b0, 4'(m_round)});
        if ((m_phase == P_SERVE) && (m_round == 0))
            chk("round0_is_key", bus.o_round_key, m_start_key);
    end

    initial begin
        logic [127:0] key;
        logic [7:0]   inv;
        int           given;
        int           guard;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_key = 128'h0; bus.i_next = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // FIPS key, ignored restart at E4, stall at round 5, full walk
        cyc(1'b1, K_FIPS, 1'b0);
        repeat (3) cyc(1'b0, 128'h0, 1'b0);
        cyc(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1);
        repeat (6) cyc(1'b0, 128'h0, 1'b0);
        repeat (5) cyc(1'b0, 128'h0, 1'b1);
        repeat (7) cyc(1'b0, 128'h0, 1'b0);
        repeat (6) cyc(1'b0, 128'h0, 1'b1);
        repeat (2) cyc(1'b0, 128'h0, 1'b0);

        // Abort at round 6 with a new key, then full walk of that key
        cyc(1'b1, K_FIPS, 1'b0);
        repeat (10) cyc(1'b0, 128'h0, 1'b0);
        repeat (4) cyc(1'b0, 128'h0, 1'b1);
        cyc(1'b1, 128'hffeeddccbbaa99887766554433221100, 1'b1);
        repeat (10) cyc(1'b0, 128'h0, 1'b0);
        repeat (11) cyc(1'b0, 128'h0, 1'b1);
        repeat (2) cyc(1'b0, 128'h0, 1'b0);

        // Start and next together in IDLE, then async reset mid-expansion
        cyc(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        repeat (4) cyc(1'b0, 128'h0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) cyc(1'b0, 128'h0, 1'b0);

        // Random keys, random ignored inputs during expansion, random stalls
        for (int k = 0; k < 10; k++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            cyc(1'b1, key, 1'b0);
            for (int c = 0; c < 10; c++)
                cyc(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom_range(0, 1)));
            given = 0;
            guard = 0;
            while ((given < 11) && (guard < 500)) begin
                if ($urandom_range(0, 3) != 0) begin
                    cyc(1'b0, 128'h0, 1'b1);
                    given++;
                end else begin
                    cyc(1'b0, 128'h0, 1'b0);
                end
                guard++;
            end
            repeat (2) cyc(1'b0, 128'h0, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
